// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write port driven by the UART program loader.
interface uart_prog_loader_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [31:0]       mem_wdata_o;

   modport master (output mem_we_o, output mem_addr_o, output mem_wdata_o);
   modport slave  (input  mem_we_o, input  mem_addr_o, input  mem_wdata_o);
endinterface

// File: rtl/uart_prog_loader.sv
// 8N1 UART receiver that packs bytes little-endian into 32-bit words and
// writes them to instruction memory until a fixed end-marker word arrives.
module uart_prog_loader #(
   parameter int unsigned CLKS_PER_BIT = 347,
   parameter int unsigned ADDR_W       = 10,
   parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
   input  logic              clock,
   input  logic              resetb,
   input  logic              rx_i,
   output logic              byte_valid_o,
   output logic [7:0]        byte_o,
   output logic              frame_err_o,
   output logic              prog_done_o,
   uart_prog_loader_if.master mem
);
   localparam int unsigned      CNT_W    = 16;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [1:0]        sync_q, sync_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic [1:0]        k_q, k_d;
   logic [31:0]       word_q, word_d;
   logic              word_rdy_q, word_rdy_d;
   logic              byte_valid_q, byte_valid_d;
   logic [7:0]        byte_q, byte_d;
   logic              frame_err_q, frame_err_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] nxt_addr_q, nxt_addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              done_q, done_d;
   logic              rxs;
   logic [31:0]       asm_word;

   assign rxs    = sync_q[1];
   assign sync_d = {sync_q[0], rx_i};

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q      <= S_IDLE;
         sync_q       <= 2'b11;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         k_q          <= '0;
         word_q       <= '0;
         word_rdy_q   <= 1'b0;
         byte_valid_q <= 1'b0;
         byte_q       <= '0;
         frame_err_q  <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         nxt_addr_q   <= '0;
         wdata_q      <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         k_q          <= k_d;
         word_q       <= word_d;
         word_rdy_q   <= word_rdy_d;
         byte_valid_q <= byte_valid_d;
         byte_q       <= byte_d;
         frame_err_q  <= frame_err_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         nxt_addr_q   <= nxt_addr_d;
         wdata_q      <= wdata_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      k_d          = k_q;
      word_d       = word_q;
      word_rdy_d   = 1'b0;
      byte_valid_d = 1'b0;
      byte_d       = byte_q;
      frame_err_d  = 1'b0;
      we_d         = 1'b0;
      addr_d       = addr_q;
      nxt_addr_d   = nxt_addr_q;
      wdata_d      = wdata_q;
      done_d       = done_q;

      // Current word with the just-received byte dropped into lane k.
      asm_word = word_q;
      asm_word[{k_q, 3'b000} +: 8] = shift_q;

      case (state_q)
         S_IDLE: begin
            if (!rxs) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == HALF_BIT) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rxs ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rxs, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               if (rxs) begin
                  byte_valid_d = 1'b1;
                  byte_d       = shift_q;
                  word_d       = asm_word;
                  k_d          = k_q + 2'd1;
                  if (k_q == 2'd3) begin
                     word_rdy_d = 1'b1;
                     if (asm_word == END_WORD) state_d = S_DONE;
                  end
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase

      // Completed word: either terminate loading or issue the memory write.
      if (word_rdy_q) begin
         if (word_q == END_WORD) begin
            done_d = 1'b1;
         end else begin
            we_d       = 1'b1;
            addr_d     = nxt_addr_q;
            wdata_d    = word_q;
            nxt_addr_d = nxt_addr_q + ADDR_W'(4);
         end
      end
   end

   assign byte_valid_o    = byte_valid_q;
   assign byte_o          = byte_q;
   assign frame_err_o     = frame_err_q;
   assign prog_done_o     = done_q;
   assign mem.mem_we_o    = we_q;
   assign mem.mem_addr_o  = addr_q;
   assign mem.mem_wdata_o = wdata_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: fixed vector table, hand-written
// reset/glitch sequences and a randomized stream against a queue-based model.
module tb_uart_prog_loader;
   localparam int unsigned C     = 16;
   localparam int unsigned AW    = 4;
   localparam logic [31:0] END_W = 32'h0000_0FFF;

   logic          clock  = 1'b0;
   logic          resetb = 1'b0;
   logic          rx_i   = 1'b1;
   logic          byte_valid_o;
   logic [7:0]    byte_o;
   logic          frame_err_o;
   logic          prog_done_o;

   uart_prog_loader_if #(.ADDR_W(AW)) mem_if ();

   uart_prog_loader #(.CLKS_PER_BIT(C), .ADDR_W(AW), .END_WORD(END_W)) dut (
      .clock        (clock),
      .resetb       (resetb),
      .rx_i         (rx_i),
      .byte_valid_o (byte_valid_o),
      .byte_o       (byte_o),
      .frame_err_o  (frame_err_o),
      .prog_done_o  (prog_done_o),
      .mem          (mem_if)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   typedef struct {
      logic [7:0]    data;
      bit            stop_ok;
      bit            exp_bv;
      bit            exp_fe;
      bit            exp_we;
      logic [AW-1:0] exp_addr;
      logic [31:0]   exp_wdata;
      bit            exp_done;
   } vec_t;

   int         vectors     = 0;
   int         miscompares = 0;
   int         cyc         = 0;
   int         last_bv_cyc = -10;
   logic       done_prev   = 1'b0;

   logic [7:0] got_b[$];
   logic [7:0] exp_b[$];
   wr_t        got_w[$];
   wr_t        exp_w[$];
   int         got_fe      = 0;
   int         exp_fe      = 0;
   bit         exp_done    = 1'b0;

   logic [7:0]    m_lane[$];
   logic [AW-1:0] m_addr = '0;
   bit            m_done = 1'b0;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Output monitor: collects events and checks write/done latency.
   always @(negedge clock) begin
      cyc++;
      if (!resetb) begin
         done_prev   = 1'b0;
         last_bv_cyc = -10;
      end else begin
         if (byte_valid_o) begin
            got_b.push_back(byte_o);
            last_bv_cyc = cyc;
         end
         if (frame_err_o) got_fe++;
         if (mem_if.mem_we_o) begin
            got_w.push_back('{mem_if.mem_addr_o, mem_if.mem_wdata_o});
            cmp("we_latency", 64'(cyc), 64'(last_bv_cyc + 1));
         end
         if (prog_done_o && !done_prev) cmp("done_latency", 64'(cyc), 64'(last_bv_cyc + 1));
         if (done_prev) cmp("done_sticky", 64'(prog_done_o), 64'd1);
         done_prev = prog_done_o;
      end
   end

   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      rx_i = 1'b0;
      tick(C);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         tick(C);
      end
      if (stop_ok) begin
         rx_i = 1'b1;
         tick(C);
      end else begin
         rx_i = 1'b0;
         tick(C / 2 + 2);
         rx_i = 1'b1;
         tick(C / 2 - 2 + 2 * C);
      end
   endtask

   task automatic check_flush(input string name);
      cmp({name, " n_bytes"}, 64'(got_b.size()), 64'(exp_b.size()));
      while (got_b.size() > 0 && exp_b.size() > 0)
         cmp({name, " byte"}, 64'(got_b.pop_front()), 64'(exp_b.pop_front()));
      cmp({name, " n_writes"}, 64'(got_w.size()), 64'(exp_w.size()));
      while (got_w.size() > 0 && exp_w.size() > 0) begin
         wr_t g, e;
         g = got_w.pop_front();
         e = exp_w.pop_front();
         cmp({name, " addr"}, 64'(g.addr), 64'(e.addr));
         cmp({name, " wdata"}, 64'(g.data), 64'(e.data));
      end
      cmp({name, " frame_err"}, 64'(got_fe), 64'(exp_fe));
      cmp({name, " done"}, 64'(prog_done_o), 64'(exp_done));
      got_b.delete(); exp_b.delete(); got_w.delete(); exp_w.delete();
      got_fe = 0; exp_fe = 0;
   endtask

   task automatic model_reset();
      m_lane.delete();
      m_addr   = '0;
      m_done   = 1'b0;
      exp_done = 1'b0;
      got_b.delete(); exp_b.delete(); got_w.delete(); exp_w.delete();
      got_fe = 0; exp_fe = 0;
   endtask

   // Reference: bytes pack little-endian, four per word, end marker stops all.
   task automatic model_frame(input logic [7:0] b, input bit ok);
      logic [31:0] w;
      if (m_done) return;
      if (!ok) begin
         exp_fe++;
         return;
      end
      exp_b.push_back(b);
      m_lane.push_back(b);
      if (m_lane.size() == 4) begin
         w = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
         m_lane.delete();
         if (w == END_W) begin
            m_done   = 1'b1;
            exp_done = 1'b1;
         end else begin
            exp_w.push_back('{m_addr, w});
            m_addr = m_addr + AW'(4);
         end
      end
   endtask

   task automatic check_reset_outs(input string name);
      cmp(name, 64'({byte_valid_o, byte_o, frame_err_o, mem_if.mem_we_o,
                     mem_if.mem_addr_o, mem_if.mem_wdata_o, prog_done_o}), 64'd0);
   endtask

   vec_t tbl[24];

   initial begin
      tbl[0]  = '{8'h91, 1, 1, 0, 0, 4'h0, 32'h0,         0};
      tbl[1]  = '{8'hED, 1, 1, 0, 0, 4'h0, 32'h0,         0};
      tbl[2]  = '{8'h08, 1, 1, 0, 0, 4'h0, 32'h0,         0};
      tbl[3]  = '{8'h42, 1, 1, 0, 1, 4'h0, 32'h4208ED91, 0};
      tbl[4]  = '{8'hA5, 0, 0, 1, 0, 4'h0, 32'h0,         0};
      tbl[5]  = '{8'h11, 1, 1, 0, 0, 4'h0, 32'h0,         0};
      tbl[6]  = '{8'h22, 1, 1, 0, 0, 4'h0, 32'h0,         0};
      tbl[7]  = '{8'h33, 1, 1, 0, 0, 4'h0, 32'h0,         0};
      tbl[8]  = '{8'h44, 1, 1, 0, 1, 4'h4, 32'h44332211, 0};
      tbl[9]  = '{8'hF2, 1, 1, 0, 0, 4'h0, 32'h0,         0};
      tbl[10] = '{8'hD2, 1, 1, 0, 0, 4'h0, 32'h0,         0};
      tbl[11] = '{8'hAD, 1, 1, 0, 0, 4'h0, 32'h0,         0};
      tbl[12] = '{8'h70, 1, 1, 0, 1, 4'h8, 32'h70ADD2F2, 0};
      tbl[13] = '{8'h7B, 1, 1, 0, 0, 4'h0, 32'h0,         0};
      tbl[14] = '{8'h08, 1, 1, 0, 0, 4'h0, 32'h0,         0};
      tbl[15] = '{8'h3C, 1, 1, 0, 0, 4'h0, 32'h0,         0};
      tbl[16] = '{8'hC6, 1, 1, 0, 1, 4'hC, 32'hC63C087B, 0};
      tbl[17] = '{8'hFF, 1, 1, 0, 0, 4'h0, 32'h0,         0};
      tbl[18] = '{8'h0F, 1, 1, 0, 0, 4'h0, 32'h0,         0};
      tbl[19] = '{8'h00, 1, 1, 0, 0, 4'h0, 32'h0,         0};
      tbl[20] = '{8'h00, 1, 1, 0, 0, 4'h0, 32'h0,         1};
      tbl[21] = '{8'h12, 1, 0, 0, 0, 4'h0, 32'h0,         1};
      tbl[22] = '{8'h34, 1, 0, 0, 0, 4'h0, 32'h0,         1};
      tbl[23] = '{8'h56, 0, 0, 0, 0, 4'h0, 32'h0,         1};

      // Reset held with the line toggling: everything stays at zero.
      resetb = 1'b0;
      for (int i = 0; i < 10; i++) begin
         rx_i = i[0];
         tick(1);
         check_reset_outs("reset_hold");
      end
      rx_i = 1'b1;
      tick(3);
      resetb = 1'b1;
      tick(C);
      check_reset_outs("reset_release");
      model_reset();

      // Directed table, frames back-to-back.
      for (int i = 0; i < 24; i++) begin
         send_frame(tbl[i].data, tbl[i].stop_ok);
         if (tbl[i].exp_bv) exp_b.push_back(tbl[i].data);
         if (tbl[i].exp_fe) exp_fe++;
         if (tbl[i].exp_we) exp_w.push_back('{tbl[i].exp_addr, tbl[i].exp_wdata});
         exp_done = tbl[i].exp_done;
         check_flush($sformatf("tbl%0d", i));
      end
      cmp("byte_o_hold_after_done", 64'(byte_o), 64'h00);

      resetb = 1'b0;
      tick(2);
      check_reset_outs("reset_after_done");
      resetb = 1'b1;
      tick(4);
      model_reset();

      // Short low glitch must be rejected; next byte still lands cleanly.
      rx_i = 1'b0;
      tick(C / 4);
      rx_i = 1'b1;
      tick(2 * C);
      check_flush("glitch");
      model_frame(8'h5A, 1'b1);
      send_frame(8'h5A, 1'b1);
      check_flush("after_glitch");
      cmp("byte_o_5a", 64'(byte_o), 64'h5A);
      model_frame(8'hAA, 1'b1);
      send_frame(8'hAA, 1'b1);
      model_frame(8'hBB, 1'b1);
      send_frame(8'hBB, 1'b1);
      check_flush("partial_word");

      // Reset mid-frame: partial word is dropped, addressing restarts at 0.
      rx_i = 1'b0;
      tick(3 * C);
      resetb = 1'b0;
      tick(2);
      check_reset_outs("reset_mid_frame");
      rx_i   = 1'b1;
      resetb = 1'b1;
      tick(4);
      model_reset();
      for (int i = 1; i <= 4; i++) begin
         model_frame(8'(i), 1'b1);
         send_frame(8'(i), 1'b1);
      end
      check_flush("after_mid_reset");

      // Randomized stream with occasional framing errors; addresses wrap.
      resetb = 1'b0;
      tick(2);
      resetb = 1'b1;
      tick(4);
      model_reset();
      for (int i = 0; i < 48; i++) begin
         logic [7:0] b;
         bit         ok;
         b  = 8'($urandom);
         ok = ($urandom_range(0, 7) != 0);
         model_frame(b, ok);
         send_frame(b, ok);
         tick($urandom_range(0, 20));
         check_flush($sformatf("rand%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
